// File: rtl/pgr_fifo_pkg.sv
// Shared helpers for the pgr stream FIFO family.
// Holds the width helper and the configuration sanity check.
package pgr_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit fifo_cfg_ok(
    input int depth,
    input int af_th,
    input int ae_th
  );
    bit ok;
    ok = (depth >= 4);
    ok = ok && ((depth & (depth - 1)) == 0);
    ok = ok && (af_th >= 1) && (af_th <= depth);
    ok = ok && (ae_th >= 0) && (ae_th < depth);
    return ok;
  endfunction

endpackage

// File: rtl/pgr_fifo_ram_dist.sv
// Distributed storage for the FIFO body.
// Synchronous write, asynchronous read, no per-entry reset.
module pgr_fifo_ram_dist
  import pgr_fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 15,
  localparam int AW = clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [N];

  // Write port; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pgr_stream_fifo_lvl.sv
// FWFT stream FIFO with registered head, level and flags.
// Capacity is DEPTH-1 RAM entries plus the output register.
module pgr_stream_fifo_lvl
  import pgr_fifo_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  localparam int LW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] data_in,
  input  logic          data_in_valid,
  output logic          data_in_ready,
  output logic [DW-1:0] data_out,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [LW-1:0] max_level,
  input  logic          wm_clr
);

  localparam int N  = DEPTH - 1;
  localparam int AW = clog2(N);

`ifdef SIM
  if (!fifo_cfg_ok(DEPTH, AF_TH, AE_TH)) begin : g_cfg_err
    $error("pgr_stream_fifo_lvl: bad DEPTH/AF_TH/AE_TH");
  end
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] max_q, max_d;
  logic [DW-1:0] od_q, od_d;
  logic          ov_q, ov_d;
  logic          rdy_q, rdy_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;

  logic          push, pop, take, ram_we;
  logic [DW-1:0] ram_rdata;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(N - 1)) ? '0 : p + AW'(1);
  endfunction

  pgr_fifo_ram_dist #(
    .DW (DW),
    .N  (N)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Next-state: head refill, RAM write, level, flags, watermark.
  always_comb begin
    push     = data_in_valid & rdy_q;
    pop      = ov_q & data_out_ready;
    take     = ~ov_q | pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    od_d     = od_q;
    ov_d     = ov_q;
    ram_we   = 1'b0;
    if (take) begin
      if (cnt_q != '0) begin
        od_d     = ram_rdata;
        ov_d     = 1'b1;
        rd_ptr_d = inc(rd_ptr_q);
        cnt_d    = cnt_q - LW'(1);
      end else if (push) begin
        od_d = data_in;
        ov_d = 1'b1;
      end else begin
        ov_d = 1'b0;
      end
    end
    if (push && !(take && cnt_q == '0)) begin
      ram_we   = 1'b1;
      wr_ptr_d = inc(wr_ptr_q);
      cnt_d    = cnt_d + LW'(1);
    end
    if (push && !pop) lvl_d = lvl_q + LW'(1);
    if (pop && !push) lvl_d = lvl_q - LW'(1);
    if (flush) begin
      ram_we   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      lvl_d    = '0;
      ov_d     = 1'b0;
    end
    rdy_d = (lvl_d < LW'(DEPTH));
    af_d  = (lvl_d >= LW'(AF_TH));
    ae_d  = (lvl_d <= LW'(AE_TH));
    max_d = max_q;
    if (wm_clr) begin
      max_d = (lvl_d > lvl_q) ? lvl_d : lvl_q;
    end else if (lvl_d > max_q) begin
      max_d = lvl_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lvl_q    <= '0;
      max_q    <= '0;
      od_q     <= '0;
      ov_q     <= 1'b0;
      rdy_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      max_q    <= max_d;
      od_q     <= od_d;
      ov_q     <= ov_d;
      rdy_q    <= rdy_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign data_in_ready  = rdy_q;
  assign data_out       = od_q;
  assign data_out_valid = ov_q;
  assign level          = lvl_q;
  assign almost_full    = af_q;
  assign almost_empty   = ae_q;
  assign max_level      = max_q;

endmodule

// File: doc/pgr_stream_fifo_lvl.md
Name: pgr_stream_fifo_lvl

Overview:
Parametrised successor to the fixed 8-bit UART-path prefetch FIFO. It is a single-clock, first-word-fall-through FIFO with a registered output and a valid/ready stream interface on both sides. Width and depth are parameters. It adds a level counter, programmable almost-full/almost-empty flags, a synchronous flush, and a peak-level watermark. It sits between the UART byte engine and 32-bit packers/unpackers in the uart_ctrl_32bit path.

Parameters:
DW, 8, data width in bits (1..64)
DEPTH, 16, total capacity in words including the output register; power of 2, >=4
AF_TH, DEPTH-2, almost_full asserts when level >= AF_TH (1..DEPTH)
AE_TH, 2, almost_empty asserts when level <= AE_TH (0..DEPTH-1)
LW, $clog2(DEPTH+1), level/watermark width (derived, localparam)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents, 1-cycle pulse or level
data_in  in  DW  write data
data_in_valid  in  1  write request
data_in_ready  out  1  FIFO can accept a word this cycle
data_out  out  DW  head word
data_out_valid  out  1  data_out holds a valid word
data_out_ready  in  1  consumer accepts head this cycle
level  out  LW  words held, 0..DEPTH
almost_full  out  1  level >= AF_TH
almost_empty  out  1  level <= AE_TH
max_level  out  LW  highest level seen since reset/wm_clr
wm_clr  in  1  clear max_level to current level

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Push: data_in_valid & data_in_ready. Pop: data_out_valid & data_out_ready.
- All outputs are registered.
- Reset values (cycle after rst sampled high): level=0, data_out_valid=0, data_out=0, data_in_ready=0, almost_full=0, almost_empty=1, max_level=0.
- data_in_ready rises the first cycle after rst deasserts.
- data_in_ready equals (next_level < DEPTH), registered.
- No combinational path exists from data_out_ready to data_in_ready.
- Latency: a word pushed into an empty FIFO at cycle N appears with data_out_valid=1 at cycle N+1.
- Output order is strict FIFO. data_out is stable while data_out_valid=1 and data_out_ready=0.
- Level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (level=DEPTH): data_in_ready=0 and data_in_valid is ignored. There is no pass-through, even with a simultaneous pop; ready returns the cycle after the pop.
- Empty: data_out_valid=0, data_out_ready is ignored, and data_out holds its last value.
- Pointers wrap modulo DEPTH-1 storage entries plus 1 output register. Wrap must be invisible at the ports.
- Flush: the next cycle gives level=0, data_out_valid=0, data_in_ready=1, almost_empty=1.
  - A push or pop coincident with flush is discarded.
  - Flush does not clear max_level.
- Priority: rst > flush > push/pop.
- almost_full and almost_empty are registered from next_level, so they are cycle-aligned with level.
- max_level updates to next_level whenever next_level > max_level.
  - wm_clr loads the current level.
  - wm_clr coincident with an increasing level loads next_level.
- Reset mid-operation discards all contents with no partial output. Storage RAM contents are don't-care after reset.
- Storage is distributed RAM with async read feeding the output register. Per-entry reset is not required.

Decomposition:
- Shared package pgr_fifo_pkg holds: the function clog2; localparam checks (DEPTH power of 2, AF_TH/AE_TH range), reported via $error under `ifdef SIM.
- One sub-module, pgr_fifo_ram_dist: DW x (DEPTH-1) register array, sync write, async read.
- Control, level, flags and watermark stay in the top module.

Test Plan:
- DW=8, DEPTH=8; push 0x01..0x08 back-to-back with data_out_ready=0. Require: data_in_ready=0 after 8th push, level=8, almost_full=1 from level 6, and a 9th push of 0x09 is dropped.
- From full, data_out_ready=1 for 8 cycles. Require: data_out=0x01..0x08 in order, level counts 7..0, data_out_valid=0 after the last word, almost_empty=1 at level<=2.
- Single push 0xA5 into empty at cycle N. Require: data_out_valid=1 and data_out=0xA5 at N+1, level=1.
- At level 3, hold push and pop for 20 cycles with an incrementing pattern. Require: level stays 3 and output order is preserved across pointer wrap.
- At level 5, pulse flush with a simultaneous push of 0x77. Require next cycle: level=0, data_out_valid=0, data_in_ready=1, max_level=5, and 0x77 never appears. Then pulse wm_clr. Require: max_level=0.
- At level 4, assert rst for 1 cycle mid-stream. Require next cycle: all reset values, and ready=1 the cycle after rst drops.
